// File: rtl/sdram_port_pkg.sv
// Shared types for the toggle req/ack port responder: FSM states, bus widths
// and the "write with no byte lanes" test.
package sdram_port_pkg;

   localparam int DS_W = 2;
   localparam int DW   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic ds_none(input logic [DS_W-1:0] ds);
      return ds == '0;
   endfunction

endpackage

// File: rtl/port_wdog.sv
// Backend wait watchdog: counts stalled ISSUE cycles and fires on the cycle that would reach TIMEOUT.
// Zero latency on expired; TIMEOUT=0 disables it (expired stuck at 0).
module port_wdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] cnt;

   // Saturates at LAST so the count can never wrap while waiting.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (run && (cnt != LAST)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (TIMEOUT != 0) && run && (cnt == LAST);

endmodule

// File: rtl/sdram_port_responder.sv
// Toggle req/ack responder driving one memory access per request; ack flips 2 edges after accept
// (1 for a strobe-less write); backend stalls via mem_rdy, aborted after TIMEOUT ISSUE cycles.
module sdram_port_responder
   import sdram_port_pkg::*;
#(
   parameter int AW      = 22,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   input  logic            port_req,
   output logic            port_ack,
   input  logic            port_we,
   input  logic [AW-1:0]   port_a,
   input  logic [DS_W-1:0] port_ds,
   input  logic [DW-1:0]   port_d,
   output logic [DW-1:0]   port_q,
   output logic            mem_cs,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DS_W-1:0] mem_be,
   output logic [DW-1:0]   mem_wdata,
   input  logic            mem_rdy,
   input  logic [DW-1:0]   mem_rdata,
   output logic            busy,
   output logic            err
);

   state_t state;
   state_t state_nxt;
   logic   pending;
   logic   null_wr;
   logic   wd_clr;
   logic   wd_run;
   logic   expired;

   assign pending = port_req != port_ack;
   assign null_wr = port_we && ds_none(port_ds);
   assign busy    = state != IDLE;
   assign wd_clr  = state != ISSUE;
   assign wd_run  = (state == ISSUE) && !mem_rdy;

   port_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clr     (wd_clr),
      .run     (wd_run),
      .expired (expired)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pending) state_nxt = null_wr ? DONE : ISSUE;
         ISSUE:   if (mem_rdy || expired) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command registers double as the backend bus, so mem_* hold still through ISSUE.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         port_ack  <= 1'b0;
         port_q    <= '0;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pending) begin
                  mem_we    <= port_we;
                  mem_addr  <= port_a;
                  mem_be    <= port_ds;
                  mem_wdata <= port_d;
                  mem_cs    <= !null_wr;
               end
            end
            ISSUE: begin
               if (mem_rdy) begin
                  mem_cs <= 1'b0;
                  if (!mem_we) port_q <= mem_rdata;
               end else if (expired) begin
                  mem_cs <= 1'b0;
                  err    <= 1'b1;
               end
            end
            DONE: begin
               port_ack <= ~port_ack;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_responder.sv
// Scoreboard bench for sdram_port_responder: stimulus queues expected responses,
// a monitor checks them on every port_ack toggle against a modelled backend.
module tb_sdram_port_responder;

   localparam int AW = 22;

   logic          clk_sys   = 1'b0;
   logic          reset_n   = 1'b0;
   logic          port_req  = 1'b0;
   logic          port_we   = 1'b0;
   logic [AW-1:0] port_a    = '0;
   logic [1:0]    port_ds   = '0;
   logic [15:0]   port_d    = '0;
   logic          mem_rdy   = 1'b0;
   logic [15:0]   mem_rdata = '0;
   logic          port_ack, mem_cs, mem_we, busy, err;
   logic [15:0]   port_q, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_be;

   sdram_port_responder #(.AW(AW), .TIMEOUT(4)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .port_req  (port_req),
      .port_ack  (port_ack),
      .port_we   (port_we),
      .port_a    (port_a),
      .port_ds   (port_ds),
      .port_d    (port_d),
      .port_q    (port_q),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdy   (mem_rdy),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [15:0]   q;
      logic          e;
      int            flip_edge;
      int            cs;
      logic          we;
      logic [AW-1:0] a;
      logic [1:0]    ds;
      logic [15:0]   d;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0, n_err = 0;
   int edge_cnt = 0, rdy_delay = 0, cs_count = 0, bursts = 0;
   int last_flip = 0, last_e0 = 0;
   logic          unstable = 1'b0, cap_we = 1'b0;
   logic [AW-1:0] cap_a  = '0;
   logic [1:0]    cap_be = '0;
   logic [15:0]   cap_wd = '0;
   logic [15:0]   bmem   [int];
   logic [15:0]   refmem [int];

   always @(posedge clk_sys) edge_cnt++;

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] be,
                                         input logic [15:0] wd);
      return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
   endfunction

   function automatic logic [15:0] ref_rd(input int a);
      return refmem.exists(a) ? refmem[a] : 16'h0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
      end
   endtask

   task automatic report();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
   endtask

   // Backend model: mem_rdy after rdy_delay cs cycles (-1 = never); noise on mem_rdy outside ISSUE.
   initial begin
      int   cyc = 0;
      logic prev_cs = 1'b0;
      int   ai;
      forever begin
         @(negedge clk_sys);
         if (!reset_n) begin
            cyc = 0; prev_cs = 1'b0; mem_rdy = 1'b0;
         end else if (mem_cs) begin
            if (!prev_cs) begin
               bursts++;
               cap_we = mem_we; cap_a = mem_addr; cap_be = mem_be; cap_wd = mem_wdata;
            end else if (mem_we !== cap_we || mem_addr !== cap_a || mem_be !== cap_be ||
                         mem_wdata !== cap_wd) begin
               unstable = 1'b1;
            end
            cs_count++;
            ai = int'(mem_addr);
            if (cyc == rdy_delay) begin
               mem_rdy   = 1'b1;
               mem_rdata = bmem.exists(ai) ? bmem[ai] : 16'h0000;
               if (mem_we) bmem[ai] = merge(bmem.exists(ai) ? bmem[ai] : 16'h0000, mem_be, mem_wdata);
            end else begin
               mem_rdy   = 1'b0;
               mem_rdata = 16'hDEAD;
            end
            cyc++;
         end else begin
            cyc       = 0;
            mem_rdy   = 1'($urandom_range(0, 1));
            mem_rdata = 16'hDEAD;
         end
         prev_cs = mem_cs;
      end
   end

   // Monitor: every port_ack toggle retires one scoreboard entry.
   initial begin
      logic last_ack = 1'b0;
      exp_t x;
      forever begin
         @(negedge clk_sys);
         if (!reset_n) begin
            last_ack = 1'b0; cs_count = 0; bursts = 0; unstable = 1'b0;
         end else if (port_ack !== last_ack) begin
            last_ack  = port_ack;
            last_flip = edge_cnt;
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_ack: port_ack=%b with nothing outstanding", port_ack);
            end else begin
               x = sb.pop_front();
               chk("port_q", 32'(port_q), 32'(x.q));
               chk("err", 32'(err), 32'(x.e));
               chk("ack_edge", edge_cnt, x.flip_edge);
               chk("cs_cycles", cs_count, x.cs);
               chk("cs_bursts", bursts, (x.cs > 0) ? 1 : 0);
               if (x.cs > 0) begin
                  chk("mem_we", 32'(cap_we), 32'(x.we));
                  chk("mem_addr", 32'(cap_a), 32'(x.a));
                  chk("mem_be", 32'(cap_be), 32'(x.ds));
                  if (x.we) chk("mem_wdata", 32'(cap_wd), 32'(x.d));
                  chk("mem_stable", 32'(unstable), 32'd0);
               end
            end
            cs_count = 0; bursts = 0; unstable = 1'b0;
         end
      end
   end

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_sys);
         if (port_ack === port_req) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL ack_wait: port_ack=%b never matched port_req=%b", port_ack, port_req);
      end
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [1:0] ds,
                        input logic [15:0] d, input int delay, input logic [15:0] eq,
                        input logic ee, input int lat, input int cs, input bit push);
      exp_t x;
      wait_idle();
      port_we = we; port_a = a; port_ds = ds; port_d = d; rdy_delay = delay;
      last_e0 = edge_cnt + 1;
      x.q = eq; x.e = ee; x.flip_edge = edge_cnt + 1 + lat; x.cs = cs;
      x.we = we; x.a = a; x.ds = ds; x.d = d;
      if (push) sb.push_back(x);
      port_req = ~port_req;
      @(posedge clk_sys);
      #1;
      // Inputs are only sampled at the accept edge; scramble them afterwards.
      port_we = ~we; port_a = ~a; port_ds = ~ds; port_d = ~d;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_port_ack"}, 32'(port_ack), 32'd0);
      chk({tag, "_port_q"}, 32'(port_q), 32'd0);
      chk({tag, "_mem_cs"}, 32'(mem_cs), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit exceeded");
      n_err++;
      report();
      $fatal(1, "time limit");
   end

   initial begin
      logic [15:0] cur_q;
      logic        we;
      logic [1:0]  ds;
      logic [15:0] d;
      int          a, first_e0, exp_cycles;
      bit          ok;

      bmem[7] = 16'hBEEF; refmem[7] = 16'hBEEF;
      repeat (2) @(negedge clk_sys);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk_sys);
      chk("idle_busy", 32'(busy), 32'd0);

      // Write, backend ready in 2nd ISSUE cycle; port_q untouched.
      issue(1'b1, 22'h001234, 2'b01, 16'hA55A, 1, 16'h0000, 1'b0, 3, 2, 1'b1);
      refmem[32'h1234] = merge(ref_rd(32'h1234), 2'b01, 16'hA55A);
      // Read with immediate ready.
      issue(1'b0, 22'h000007, 2'b11, 16'h0000, 0, 16'hBEEF, 1'b0, 2, 1, 1'b1);
      // Strobe-less write: no backend access, ack one edge after accept.
      issue(1'b1, 22'h000100, 2'b00, 16'hFFFF, 0, 16'hBEEF, 1'b0, 1, 0, 1'b1);
      // Backend never ready: 4 cs cycles, err set, port_q kept.
      issue(1'b0, 22'h000020, 2'b11, 16'h0000, -1, 16'hBEEF, 1'b1, 5, 4, 1'b1);
      // Normal accesses after the abort; err stays set.
      issue(1'b0, 22'h001234, 2'b11, 16'h0000, 0, 16'h005A, 1'b1, 2, 1, 1'b1);
      issue(1'b1, 22'h000007, 2'b10, 16'h1234, 0, 16'h005A, 1'b1, 2, 1, 1'b1);
      refmem[7] = merge(ref_rd(7), 2'b10, 16'h1234);

      // Reset with mem_cs high, then release with port_req=1 still pending.
      issue(1'b0, 22'h000007, 2'b11, 16'h0000, -1, 16'h0000, 1'b0, 0, 0, 1'b0);
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_sys);
         if (mem_cs === 1'b1) begin ok = 1'b1; break; end
      end
      chk("reset_setup_cs", 32'(ok), 32'd1);
      #1 reset_n = 1'b0;
      #1 check_all_zero("midreset");
      repeat (3) @(negedge clk_sys);
      port_we = 1'b0; port_a = 22'h000007; port_ds = 2'b11; port_d = 16'h0000; rdy_delay = 0;
      begin
         exp_t x;
         x.q = 16'h12EF; x.e = 1'b0; x.flip_edge = edge_cnt + 3; x.cs = 1;
         x.we = 1'b0; x.a = 22'h000007; x.ds = 2'b11; x.d = 16'h0000;
         sb.push_back(x);
      end
      reset_n = 1'b1;
      wait_idle();
      chk("post_reset_ack", 32'(port_ack), 32'd1);
      cur_q = 16'h12EF;

      // Back-to-back random traffic, requester re-flipping as soon as ack matches.
      exp_cycles = 0;
      first_e0   = 0;
      for (int i = 0; i < 100; i++) begin
         we = 1'($urandom_range(0, 1));
         a  = int'($urandom_range(0, 15));
         ds = 2'($urandom_range(0, 3));
         d  = 16'($urandom);
         if (we) begin
            if (ds == 2'b00) begin
               issue(we, AW'(a), ds, d, 0, cur_q, 1'b0, 1, 0, 1'b1);
               exp_cycles += 2;
            end else begin
               issue(we, AW'(a), ds, d, 0, cur_q, 1'b0, 2, 1, 1'b1);
               refmem[a] = merge(ref_rd(a), ds, d);
               exp_cycles += 3;
            end
         end else begin
            cur_q = ref_rd(a);
            issue(we, AW'(a), ds, d, 0, cur_q, 1'b0, 2, 1, 1'b1);
            exp_cycles += 3;
         end
         if (i == 0) first_e0 = last_e0;
      end
      wait_idle();
      @(negedge clk_sys);
      chk("throughput_cycles", last_flip - first_e0 + 1, exp_cycles);
      repeat (3) @(negedge clk_sys);
      chk("scoreboard_drained", sb.size(), 0);
      chk("final_busy", 32'(busy), 32'd0);

      report();
      $finish;
   end

endmodule
